// File: rtl/pwm_seq_pkg.sv
// rtl/pwm_seq_pkg.sv - shared state encoding, default sizes and frame type for the PWM duty sequencer
package pwm_seq_pkg;

  localparam int CRX_WIDTH_DEF  = 16;
  localparam int CH_NUM_DEF     = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int HOLD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RAMP = 2'd2
  } seq_state_e;

  typedef logic [CH_NUM_DEF-1:0][CRX_WIDTH_DEF-1:0] frame_t;

endpackage

// File: rtl/pwm_seq_fifo.sv
// rtl/pwm_seq_fifo.sv - single-clock frame FIFO with synchronous flush
// Writes while full and reads while empty are ignored; flush wins over push/pop.
module pwm_seq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt == FULL_CNT);
  assign empty_o = (cnt == '0);
  assign do_push = push_i && !full_o && !flush_i && rst_n_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem[rd_ptr];
  assign cnt_o   = cnt;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pwm_duty_seq.sv
// rtl/pwm_duty_seq.sv - applies buffered duty frames to PWM compare registers at period boundaries
// Optional PWM_SEQ_RAMP_EN adds step_i and a RAMP state that slews toward each new frame.
module pwm_duty_seq
  import pwm_seq_pkg::*;
#(
  parameter int CRX_WIDTH  = CRX_WIDTH_DEF,
  parameter int CH_NUM     = CH_NUM_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int HOLD_WIDTH = HOLD_WIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic                          clr_i,
  input  logic [HOLD_WIDTH-1:0]         hold_i,
  input  logic                          period_end_i,
  input  logic                          frm_valid_i,
  output logic                          frm_ready_o,
  input  logic [CH_NUM*CRX_WIDTH-1:0]   frm_data_i,
  output logic [CH_NUM*CRX_WIDTH-1:0]   cr_o,
  output logic                          cr_upd_o,
  output logic                          busy_o,
  output logic                          underrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
`ifdef PWM_SEQ_RAMP_EN
  ,
  input  logic [CRX_WIDTH-1:0]          step_i
`endif
);

  typedef logic [CH_NUM-1:0][CRX_WIDTH-1:0] cr_frame_t;

  seq_state_e            state, state_n;
  cr_frame_t             cr_q, cr_n;
  cr_frame_t             fifo_data;
  logic [HOLD_WIDTH-1:0] hold_cnt, hold_n, hold_load;
  logic                  und_q, und_n;
  logic                  upd_q, upd_n;
  logic                  busy_q;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, load;
`ifdef PWM_SEQ_RAMP_EN
  cr_frame_t             tgt_q, tgt_n;

  // Per channel: move by step, but never overshoot; a zero step lands on target at once.
  function automatic cr_frame_t ramp_toward(cr_frame_t cur, cr_frame_t tgt,
                                            logic [CRX_WIDTH-1:0] stp);
    cr_frame_t            r;
    logic [CRX_WIDTH-1:0] diff;
    r    = tgt;
    diff = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (cur[k] < tgt[k]) begin
        diff = tgt[k] - cur[k];
        if (stp != '0 && stp < diff) r[k] = cur[k] + stp;
      end else begin
        diff = cur[k] - tgt[k];
        if (stp != '0 && stp < diff) r[k] = cur[k] - stp;
      end
    end
    return r;
  endfunction
`endif

  assign frm_ready_o = !fifo_full && !clr_i;
  assign push        = frm_valid_i && frm_ready_o;
  assign hold_load   = (hold_i == '0) ? '0 : hold_i - 1'b1;

  pwm_seq_fifo #(
    .WIDTH (CH_NUM*CRX_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (clr_i),
    .push_i  (push),
    .data_i  (frm_data_i),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt_o)
  );

  always_comb begin
    state_n = state;
    cr_n    = cr_q;
    hold_n  = hold_cnt;
    und_n   = und_q;
    upd_n   = 1'b0;
    pop     = 1'b0;
    load    = 1'b0;
`ifdef PWM_SEQ_RAMP_EN
    tgt_n   = tgt_q;
`endif
    if (clr_i) begin
      state_n = IDLE;
      und_n   = 1'b0;
    end else if (!en_i) begin
      state_n = IDLE;
    end else if (period_end_i) begin
      case (state)
        IDLE: load = !fifo_empty;
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_n = hold_cnt - 1'b1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            und_n   = 1'b1;
            state_n = IDLE;
          end
        end
`ifdef PWM_SEQ_RAMP_EN
        RAMP: begin
          cr_n  = ramp_toward(cr_q, tgt_q, step_i);
          upd_n = 1'b1;
          if (cr_n == tgt_q) begin
            hold_n  = hold_load;
            state_n = HOLD;
          end
        end
`endif
        default: state_n = IDLE;
      endcase
    end

    // Back-to-back loads reuse this path so there is never a gap period between frames.
    if (load) begin
      pop    = 1'b1;
      upd_n  = 1'b1;
      hold_n = hold_load;
`ifdef PWM_SEQ_RAMP_EN
      tgt_n   = fifo_data;
      cr_n    = ramp_toward(cr_q, fifo_data, step_i);
      state_n = (cr_n == fifo_data) ? HOLD : RAMP;
`else
      cr_n    = fifo_data;
      state_n = HOLD;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      cr_q     <= '0;
      hold_cnt <= '0;
      und_q    <= 1'b0;
      upd_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef PWM_SEQ_RAMP_EN
      tgt_q    <= '0;
`endif
    end else begin
      state    <= state_n;
      cr_q     <= cr_n;
      hold_cnt <= hold_n;
      und_q    <= und_n;
      upd_q    <= upd_n;
      busy_q   <= (state_n != IDLE);
`ifdef PWM_SEQ_RAMP_EN
      tgt_q    <= tgt_n;
`endif
    end
  end

  assign cr_o       = cr_q;
  assign cr_upd_o   = upd_q;
  assign busy_o     = busy_q;
  assign underrun_o = und_q;

endmodule
